// File: rtl/kmeans_ctrl_k2_d2.sv
// Controller for a 2-cluster, 2-dimension k-means engine: streams points through an external
// distance pipeline, accumulates per-cluster sums and recomputes centroids. Option: KMEANS_CTRL_CONVERGE_EN.
module kmeans_ctrl_k2_d2 #(
    parameter int unsigned input_data_width = 16,
    parameter int unsigned addr_width       = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [addr_width:0]         num_points,
    input  logic [7:0]                  max_iter,
    input  logic [input_data_width-1:0] init_c0_d0,
    input  logic [input_data_width-1:0] init_c0_d1,
    input  logic [input_data_width-1:0] init_c1_d0,
    input  logic [input_data_width-1:0] init_c1_d1,
    output logic                        mem_rd_en,
    output logic [addr_width-1:0]       mem_rd_addr,
    input  logic [input_data_width-1:0] mem_rd_data0,
    input  logic [input_data_width-1:0] mem_rd_data1,
    output logic [input_data_width-1:0] dp_centroid0_d0,
    output logic [input_data_width-1:0] dp_centroid0_d1,
    output logic [input_data_width-1:0] dp_centroid1_d0,
    output logic [input_data_width-1:0] dp_centroid1_d1,
    output logic [input_data_width-1:0] dp_input_data0,
    output logic [input_data_width-1:0] dp_input_data1,
    input  logic [input_data_width-1:0] dp_output_data0,
    input  logic [input_data_width-1:0] dp_output_data1,
    input  logic                        dp_selected_centroid,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  iterations,
    output logic [input_data_width-1:0] c0_d0,
    output logic [input_data_width-1:0] c0_d1,
    output logic [input_data_width-1:0] c1_d0,
    output logic [input_data_width-1:0] c1_d1
);

    localparam int unsigned W    = input_data_width;
    localparam int unsigned AW   = addr_width;
    localparam int unsigned CW   = addr_width + 1;
    localparam int unsigned SW   = input_data_width + addr_width + 1;
    localparam int unsigned CNTW = $clog2(SW + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        DRAIN  = 3'd2,
        DIVIDE = 3'd3,
        UPDATE = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]         mem_rd_addr_q, mem_rd_addr_d;
    logic [7:0]            iter_q, iter_d;
    logic [7:0]            max_iter_q, max_iter_d;
    logic [CW-1:0]         npts_q, npts_d;
    // Index order everywhere: 0=c0d0, 1=c0d1, 2=c1d0, 3=c1d1
    logic [3:0][W-1:0]     cent_q, cent_d;
    logic [3:0][W-1:0]     new_q, new_d;
    logic [3:0][SW-1:0]    sum_q, sum_d;
    logic [1:0][CW-1:0]    cnt_q, cnt_d;
    logic [4:0]            vld_q, vld_d;
    logic [1:0]            div_idx_q, div_idx_d;
    logic [CNTW-1:0]       div_cnt_q, div_cnt_d;
    logic [CW-1:0]         div_rem_q, div_rem_d;
    logic [SW-1:0]         div_dvd_q, div_dvd_d;

    logic [CW-1:0]         divisor;
    logic [CW:0]           rem_sh;
    logic [CW:0]           rem_sub;
    logic                  div_ge;
    logic [CW-1:0]         rem_nxt;
    logic [SW-1:0]         dvd_nxt;
    logic [7:0]            iter_inc;
    logic                  last_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            iter_q        <= '0;
            max_iter_q    <= '0;
            npts_q        <= '0;
            cent_q        <= '0;
            new_q         <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            vld_q         <= '0;
            div_idx_q     <= '0;
            div_cnt_q     <= '0;
            div_rem_q     <= '0;
            div_dvd_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            iter_q        <= iter_d;
            max_iter_q    <= max_iter_d;
            npts_q        <= npts_d;
            cent_q        <= cent_d;
            new_q         <= new_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            vld_q         <= vld_d;
            div_idx_q     <= div_idx_d;
            div_cnt_q     <= div_cnt_d;
            div_rem_q     <= div_rem_d;
            div_dvd_q     <= div_dvd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        iter_d        = iter_q;
        max_iter_d    = max_iter_q;
        npts_d        = npts_q;
        cent_d        = cent_q;
        new_d         = new_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        div_idx_d     = div_idx_q;
        div_cnt_d     = div_cnt_q;
        div_rem_d     = div_rem_q;
        div_dvd_d     = div_dvd_q;
        vld_d         = {vld_q[3:0], mem_rd_en_q};

        // One restoring-division step: shift in the next dividend bit, subtract if it fits
        divisor  = cnt_q[div_idx_q[1]];
        rem_sh   = {div_rem_q, div_dvd_q[SW-1]};
        div_ge   = (rem_sh >= {1'b0, divisor});
        rem_sub  = rem_sh - {1'b0, divisor};
        rem_nxt  = div_ge ? rem_sub[CW-1:0] : rem_sh[CW-1:0];
        dvd_nxt  = {div_dvd_q[SW-2:0], div_ge};
        iter_inc = iter_q + 8'd1;

`ifdef KMEANS_CTRL_CONVERGE_EN
        last_pass = (iter_inc == max_iter_q) || (new_q == cent_q);
`else
        last_pass = (iter_inc == max_iter_q);
`endif

        // The last valid-stage bit lines up with the pipeline result for that point
        if (vld_q[4]) begin
            if (dp_selected_centroid) begin
                sum_d[2] = sum_q[2] + SW'(dp_output_data0);
                sum_d[3] = sum_q[3] + SW'(dp_output_data1);
                cnt_d[1] = cnt_q[1] + CW'(1);
            end else begin
                sum_d[0] = sum_q[0] + SW'(dp_output_data0);
                sum_d[1] = sum_q[1] + SW'(dp_output_data1);
                cnt_d[0] = cnt_q[0] + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    npts_d     = num_points;
                    max_iter_d = max_iter;
                    cent_d     = {init_c1_d1, init_c1_d0, init_c0_d1, init_c0_d0};
                    iter_d     = '0;
                    sum_d      = '0;
                    cnt_d      = '0;
                    if ((num_points == '0) || (max_iter == '0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d       = STREAM;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = '0;
                    end
                end
            end
            STREAM: begin
                if ({1'b0, mem_rd_addr_q} == (npts_q - CW'(1))) begin
                    state_d = DRAIN;
                end else begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = mem_rd_addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (vld_q == '0) begin
                    state_d   = DIVIDE;
                    div_idx_d = '0;
                    div_cnt_d = '0;
                end
            end
            DIVIDE: begin
                // div_cnt_q == 0 means the next operand pair has not been loaded yet
                if (div_cnt_q == '0) begin
                    if (divisor == '0) begin
                        new_d[div_idx_q] = cent_q[div_idx_q];
                        if (div_idx_q == 2'd3) state_d = UPDATE;
                        else                   div_idx_d = div_idx_q + 2'd1;
                    end else begin
                        div_dvd_d = sum_q[div_idx_q];
                        div_rem_d = '0;
                        div_cnt_d = CNTW'(SW);
                    end
                end else begin
                    div_dvd_d = dvd_nxt;
                    div_rem_d = rem_nxt;
                    div_cnt_d = div_cnt_q - CNTW'(1);
                    if (div_cnt_q == CNTW'(1)) begin
                        new_d[div_idx_q] = W'(dvd_nxt);
                        if (div_idx_q == 2'd3) state_d = UPDATE;
                        else                   div_idx_d = div_idx_q + 2'd1;
                    end
                end
            end
            UPDATE: begin
                cent_d = new_q;
                iter_d = iter_inc;
                sum_d  = '0;
                cnt_d  = '0;
                if (last_pass) begin
                    state_d = FINISH;
                end else begin
                    state_d       = STREAM;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    assign mem_rd_en       = mem_rd_en_q;
    assign mem_rd_addr     = mem_rd_addr_q;
    assign dp_input_data0  = mem_rd_data0;
    assign dp_input_data1  = mem_rd_data1;
    assign dp_centroid0_d0 = cent_q[0];
    assign dp_centroid0_d1 = cent_q[1];
    assign dp_centroid1_d0 = cent_q[2];
    assign dp_centroid1_d1 = cent_q[3];
    assign busy            = busy_q;
    assign done            = done_q;
    assign iterations      = iter_q;
    assign c0_d0           = cent_q[0];
    assign c0_d1           = cent_q[1];
    assign c1_d0           = cent_q[2];
    assign c1_d1           = cent_q[3];

endmodule

// File: tb/tb_kmeans_ctrl_k2_d2.sv
// Directed bench for kmeans_ctrl_k2_d2 with a behavioural point memory and a 4-cycle distance pipeline.
module tb_kmeans_ctrl_k2_d2;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

`ifdef KMEANS_CTRL_CONVERGE_EN
    localparam int IT_STABLE = 1;
`else
    localparam int IT_STABLE = 5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_points;
    logic [7:0]    max_iter;
    logic [DW-1:0] init_c0_d0, init_c0_d1, init_c1_d0, init_c1_d1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data0, mem_rd_data1;
    logic [DW-1:0] dp_centroid0_d0, dp_centroid0_d1, dp_centroid1_d0, dp_centroid1_d1;
    logic [DW-1:0] dp_input_data0, dp_input_data1;
    logic [DW-1:0] dp_output_data0, dp_output_data1;
    logic          dp_selected_centroid;
    logic          busy, done;
    logic [7:0]    iterations;
    logic [DW-1:0] c0_d0, c0_d1, c1_d0, c1_d1;

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int done_total = 0;

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] pd0 [0:3];
    logic [DW-1:0] pd1 [0:3];
    logic          psel [0:3];

    kmeans_ctrl_k2_d2 dut (
        .clk(clk), .rst(rst), .start(start),
        .num_points(num_points), .max_iter(max_iter),
        .init_c0_d0(init_c0_d0), .init_c0_d1(init_c0_d1),
        .init_c1_d0(init_c1_d0), .init_c1_d1(init_c1_d1),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data0(mem_rd_data0), .mem_rd_data1(mem_rd_data1),
        .dp_centroid0_d0(dp_centroid0_d0), .dp_centroid0_d1(dp_centroid0_d1),
        .dp_centroid1_d0(dp_centroid1_d0), .dp_centroid1_d1(dp_centroid1_d1),
        .dp_input_data0(dp_input_data0), .dp_input_data1(dp_input_data1),
        .dp_output_data0(dp_output_data0), .dp_output_data1(dp_output_data1),
        .dp_selected_centroid(dp_selected_centroid),
        .busy(busy), .done(done), .iterations(iterations),
        .c0_d0(c0_d0), .c0_d1(c0_d1), .c1_d0(c1_d0), .c1_d1(c1_d1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rd_data0 <= mem_rd_en ? mem0[mem_rd_addr] : '0;
        mem_rd_data1 <= mem_rd_en ? mem1[mem_rd_addr] : '0;
    end

    // Squared-distance nearest centroid; ties go to centroid 1
    function automatic logic nearest(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                     input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                     input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        longint e0, e1, f0, f1;
        e0 = longint'(x) - longint'(a0);
        e1 = longint'(y) - longint'(a1);
        f0 = longint'(x) - longint'(b0);
        f1 = longint'(y) - longint'(b1);
        return (f0 * f0 + f1 * f1) <= (e0 * e0 + e1 * e1);
    endfunction

    always @(posedge clk) begin
        pd0[0]  <= dp_input_data0;
        pd1[0]  <= dp_input_data1;
        psel[0] <= nearest(dp_input_data0, dp_input_data1, dp_centroid0_d0, dp_centroid0_d1,
                           dp_centroid1_d0, dp_centroid1_d1);
        for (int i = 1; i < 4; i++) begin
            pd0[i]  <= pd0[i-1];
            pd1[i]  <= pd1[i-1];
            psel[i] <= psel[i-1];
        end
    end

    assign dp_output_data0      = pd0[3];
    assign dp_output_data1      = pd1[3];
    assign dp_selected_centroid = psel[3];

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) rd_total <= rd_total + 1;
        if (done === 1'b1)      done_total <= done_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_pt(input int a, input int x, input int y);
        mem0[a] = 16'(x);
        mem1[a] = 16'(y);
    endtask

    task automatic run_case(input string tag, input int np, input int mi,
                            input int i00, input int i01, input int i10, input int i11,
                            input int e00, input int e01, input int e10, input int e11,
                            input int eit, input bit poke, output int lat);
        int rd0, dn0;
        rd0 = rd_total;
        dn0 = done_total;
        @(negedge clk);
        num_points = 11'(np);
        max_iter   = 8'(mi);
        init_c0_d0 = 16'(i00);
        init_c0_d1 = 16'(i01);
        init_c1_d0 = 16'(i10);
        init_c1_d1 = 16'(i11);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            check_eq({tag, "_busy_at_poke"}, busy, 1);
            num_points = 11'd1;
            max_iter   = 8'd9;
            init_c0_d0 = 16'd7;
            init_c0_d1 = 16'd7;
            init_c1_d0 = 16'd7;
            init_c1_d1 = 16'd7;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_c0d0"}, c0_d0, e00);
        check_eq({tag, "_c0d1"}, c0_d1, e01);
        check_eq({tag, "_c1d0"}, c1_d0, e10);
        check_eq({tag, "_c1d1"}, c1_d1, e11);
        check_eq({tag, "_iter"}, iterations, eit);
        @(negedge clk);
        check_eq({tag, "_done_drop"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_hold_c1d0"}, c1_d0, e10);
        check_eq({tag, "_reads"}, rd_total - rd0, np * eit);
        check_eq({tag, "_done_pulses"}, done_total - dn0, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, mem_rd_en, 0);
        check_eq({tag, "_rd_addr"}, mem_rd_addr, 0);
        check_eq({tag, "_iter"}, iterations, 0);
        check_eq({tag, "_cents"}, {c0_d0, c0_d1}, 0);
        check_eq({tag, "_cents1"}, {c1_d0, c1_d1}, 0);
        check_eq({tag, "_dpc"}, {dp_centroid0_d0, dp_centroid1_d1}, 0);
    endtask

    initial begin
        int lat;
        rst        = 1'b1;
        start      = 1'b0;
        num_points = '0;
        max_iter   = '0;
        init_c0_d0 = '0;
        init_c0_d1 = '0;
        init_c1_d0 = '0;
        init_c1_d1 = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Already-converged clusters
        set_pt(0, 1, 1); set_pt(1, 1, 1); set_pt(2, 9, 9); set_pt(3, 9, 9);
        run_case("stable", 4, 5, 1, 1, 9, 9, 1, 1, 9, 9, IT_STABLE, 1'b0, lat);

        // Empty cluster keeps its centroid
        set_pt(0, 0, 0); set_pt(1, 4, 0);
        run_case("empty", 2, 1, 4, 0, 100, 100, 2, 0, 100, 100, 1, 1'b0, lat);

        // Equal distances resolve to centroid 1
        set_pt(0, 5, 0); set_pt(1, 3, 0);
        run_case("tie", 2, 1, 6, 0, 6, 0, 6, 0, 4, 0, 1, 1'b0, lat);

        // Floor division: (1+2)/2=1, (3+4)/2=3
        set_pt(0, 1, 3); set_pt(1, 2, 4);
        run_case("floor", 2, 1, 0, 0, 100, 100, 1, 3, 100, 100, 1, 1'b0, lat);

        // Three passes moving both centroids
        set_pt(0, 0, 0); set_pt(1, 2, 0); set_pt(2, 10, 0); set_pt(3, 12, 0);
        run_case("multi", 4, 3, 0, 0, 2, 0, 1, 0, 11, 0, 3, 1'b0, lat);

        // Full-scale coordinates, sums wider than the data path
        set_pt(0, 65535, 65535); set_pt(1, 65534, 1);
        run_case("wide", 2, 1, 0, 0, 65535, 65535, 0, 0, 65534, 32768, 1, 1'b0, lat);

        run_case("np0", 0, 4, 11, 12, 13, 14, 11, 12, 13, 14, 0, 1'b0, lat);
        check_eq("np0_latency_le3", lat <= 3, 1);
        run_case("mi0", 4, 0, 21, 22, 23, 24, 21, 22, 23, 24, 0, 1'b0, lat);

        // Reset in the middle of a 64-point stream
        for (int i = 0; i < 64; i++) set_pt(i, i * 3, 200 - i);
        @(negedge clk);
        num_points = 11'd64;
        max_iter   = 8'd3;
        init_c0_d0 = 16'd0;
        init_c0_d1 = 16'd0;
        init_c1_d0 = 16'd150;
        init_c1_d1 = 16'd150;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midrun_busy", busy, 1);
        check_eq("midrun_rd_en", mem_rd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("midrst");
        set_pt(0, 0, 0); set_pt(1, 4, 0);
        rst = 1'b0;
        run_case("after_rst", 2, 1, 4, 0, 100, 100, 2, 0, 100, 100, 1, 1'b0, lat);

        // Start pulsed while busy must not disturb the run
        set_pt(0, 5, 0); set_pt(1, 3, 0);
        run_case("poke", 2, 1, 6, 0, 6, 0, 6, 0, 4, 0, 1, 1'b1, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
